// File: rtl/fpmult_arbiter.sv
// Round-robin arbiter/sequencer sharing one fpmult among NREQ requesters.
// Optional WAIT timeout with qNaN/err response: define FPMULT_ARB_TIMEOUT_EN.
module fpmult_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_dataa,
   input  logic [NREQ*WIDTH-1:0] req_datab,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      result,
   output logic                  err,
   output logic                  busy,
   output logic [WIDTH-1:0]      mult_dataa,
   output logic [WIDTH-1:0]      mult_datab,
   output logic                  mult_start,
   input  logic [WIDTH-1:0]      mult_result,
   input  logic                  mult_done
);

   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   grant_q, grant_d;
   logic [IDXW-1:0]   last_grant_q, last_grant_d;
   logic [WIDTH-1:0]  dataa_q, dataa_d;
   logic [WIDTH-1:0]  datab_q, datab_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              wait_first_q, wait_first_d;

   logic [WIDTH-1:0]  opa [NREQ];
   logic [WIDTH-1:0]  opb [NREQ];
   logic [IDXW-1:0]   win_idx;
   logic [IDXW-1:0]   cand;
   logic              win_vld;

`ifdef FPMULT_ARB_TIMEOUT_EN
   localparam int unsigned CNTW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);
   logic [CNTW-1:0]   wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   assign err = err_q;
`else
   logic              unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign err = 1'b0;
`endif

   // Unpack operand slices per requester
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign opa[g] = req_dataa[g*WIDTH +: WIDTH];
      assign opb[g] = req_datab[g*WIDTH +: WIDTH];
   end

   // First pending request after the last grant, with wrap
   always_comb begin
      win_idx = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = IDXW'((32'(last_grant_q) + i) % NREQ);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      dataa_d      = dataa_q;
      datab_d      = datab_q;
      result_d     = result_q;
      wait_first_d = wait_first_q;
      ack_d        = '0;
`ifdef FPMULT_ARB_TIMEOUT_EN
      wait_cnt_d   = wait_cnt_q;
      err_d        = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               grant_d = win_idx;
               dataa_d = opa[win_idx];
               datab_d = opb[win_idx];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wait_first_d = 1'b1;
`ifdef FPMULT_ARB_TIMEOUT_EN
            wait_cnt_d   = '0;
`endif
            state_d      = WAIT;
         end
         WAIT: begin
            // A done seen in the first WAIT cycle may be left over from the last op
            wait_first_d = 1'b0;
            if (!wait_first_q && mult_done) begin
               result_d = mult_result;
               state_d  = RESP;
            end
`ifdef FPMULT_ARB_TIMEOUT_EN
            else if (wait_cnt_q == CNTW'(TIMEOUT)) begin
               result_d = QNAN;
               err_d    = 1'b1;
               state_d  = RESP;
            end
            wait_cnt_d = wait_cnt_q + CNTW'(1);
`endif
         end
         RESP: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == RESP) ack_d[grant_q] = 1'b1;
      start_d = (state_d == ISSUE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_RST;
         dataa_q      <= '0;
         datab_q      <= '0;
         result_q     <= '0;
         ack_q        <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         wait_first_q <= 1'b0;
`ifdef FPMULT_ARB_TIMEOUT_EN
         wait_cnt_q   <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         dataa_q      <= dataa_d;
         datab_q      <= datab_d;
         result_q     <= result_d;
         ack_q        <= ack_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         wait_first_q <= wait_first_d;
`ifdef FPMULT_ARB_TIMEOUT_EN
         wait_cnt_q   <= wait_cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   assign ack        = ack_q;
   assign result     = result_q;
   assign busy       = busy_q;
   assign mult_dataa = dataa_q;
   assign mult_datab = datab_q;
   assign mult_start = start_q;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Bench for fpmult_arbiter: fpmult latency model, requester model and ack scoreboard.
// Timeout sequence runs only when FPMULT_ARB_TIMEOUT_EN is defined.
module tb_fpmult_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req = '0;
   logic [127:0] req_dataa, req_datab;
   logic [3:0]   ack;
   logic [31:0]  result;
   logic         err, busy;
   logic [31:0]  mult_dataa, mult_datab;
   logic         mult_start;
   logic [31:0]  mult_result = '0;
   logic         mult_done = 1'b0;

   logic [31:0]  opa [4];
   logic [31:0]  opb [4];
   assign req_dataa = {opa[3], opa[2], opa[1], opa[0]};
   assign req_datab = {opb[3], opb[2], opb[1], opb[0]};

   fpmult_arbiter #(.NREQ(4), .WIDTH(32), .TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
      .ack(ack), .result(result), .err(err), .busy(busy),
      .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_start(mult_start),
      .mult_result(mult_result), .mult_done(mult_done)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; logic [31:0] res; logic err; int lat; } exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   int cyc = 0, start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference single-precision multiply for normal, exactly representable products
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      logic [9:0]  e;
      logic [22:0] f;
      m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (m[47]) begin e = e + 10'd1; f = m[46:24]; end
      else f = m[45:23];
      return {a[31] ^ b[31], e[7:0], f};
   endfunction

   // fpmult model: stale done kept through first WAIT cycle, done after lat cycles
   int   lat = 3;
   bit   never = 1'b0;
   int   mcnt = 0;
   bit   kill = 1'b0;
   logic [31:0] a_c = '0, b_c = '0;
   always @(posedge clk) begin
      if (mult_start) begin
         a_c <= mult_dataa; b_c <= mult_datab;
         mcnt <= never ? 0 : lat; kill <= never;
      end else if (kill) begin
         mult_done <= 1'b0; kill <= 1'b0;
      end else if (mcnt > 1) begin
         mcnt <= mcnt - 1; mult_done <= 1'b0;
      end else if (mcnt == 1) begin
         mcnt <= 0; mult_done <= 1'b1; mult_result <= fmul(a_c, b_c);
      end
   end

   // Requester model + scoreboard checker; sole writer of req
   logic [3:0] raise_mask = '0;
   int         raise_tok = 0, seen_tok = 0;
   int         rearm_budget = 0, rearm_used = 0;
   logic [3:0] rearm_pend = '0;
   always @(negedge clk) begin
      exp_t e;
      req = req | rearm_pend;
      rearm_pend = '0;
      if (raise_tok != seen_tok) begin
         req = req | raise_mask;
         seen_tok = raise_tok;
      end
      if (mult_start) start_cyc = cyc;
      if (ack != '0) begin
         if (sb.size() == 0) chk("unexpected_ack", 64'(ack), 64'd0);
         else begin
            e = sb.pop_front();
            chk("ack_grant", 64'(ack), 64'(4'b0001 << e.idx));
            chk("result", 64'(result), 64'(e.res));
            chk("err", 64'(err), 64'(e.err));
            chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
         end
         for (int i = 0; i < 4; i++) begin
            if (ack[2'(i)]) begin
               req[2'(i)] = 1'b0;
               if (rearm_used < rearm_budget) begin
                  rearm_pend[2'(i)] = 1'b1;
                  rearm_used++;
               end
            end
         end
      end
   end

   task automatic raise(input logic [3:0] m);
      raise_mask = m;
      raise_tok++;
   endtask

   task automatic expect_op(input int i, input logic [31:0] r, input logic e, input int l);
      exp_t x;
      x.idx = i; x.res = r; x.err = e; x.lat = l;
      sb.push_back(x);
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic do_reset(input bit check);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (check) begin
         chk("rst_ack", 64'(ack), 64'd0);
         chk("rst_result", 64'(result), 64'd0);
         chk("rst_err", 64'(err), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_start", 64'(mult_start), 64'd0);
         chk("rst_dataa", 64'(mult_dataa), 64'd0);
         chk("rst_datab", 64'(mult_datab), 64'd0);
      end
      reset = 1'b1;
   endtask

   typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic [31:0] p; int lat; } vec_t;
   vec_t tv [6];

   initial begin
      tv[0] = '{2, 32'h3f800000, 32'h40000000, 32'h40000000, 3};
      tv[1] = '{0, 32'h40000000, 32'h40400000, 32'h40c00000, 1};
      tv[2] = '{3, 32'h3fc00000, 32'h40800000, 32'h40c00000, 5};
      tv[3] = '{1, 32'h40a00000, 32'h3f000000, 32'h40200000, 2};
      tv[4] = '{2, 32'h41200000, 32'h41200000, 32'h42c80000, 4};
      tv[5] = '{0, 32'hc0000000, 32'h40400000, 32'hc0c00000, 2};
      for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end

      do_reset(1'b1);

      // Single requester transactions, varying latency
      for (int t = 0; t < 6; t++) begin
         opa[2'(tv[t].idx)] = tv[t].a;
         opb[2'(tv[t].idx)] = tv[t].b;
         lat = tv[t].lat;
         expect_op(tv[t].idx, tv[t].p, 1'b0, tv[t].lat + 2);
         raise(4'(1 << tv[t].idx));
         repeat (2) @(posedge clk);
         #1 chk("busy_during_op", 64'(busy), 64'd1);
         drain("single", 60);
         #1 chk("busy_after_ack", 64'(busy), 64'd0);
      end

      // All four at once after reset: served 0,1,2,3
      @(posedge clk);
      do_reset(1'b0);
      opa[0] = 32'h40000000; opb[0] = 32'h40400000;
      opa[1] = 32'h40a00000; opb[1] = 32'h3f000000;
      opa[2] = 32'h3f800000; opb[2] = 32'h40000000;
      opa[3] = 32'h41200000; opb[3] = 32'h41200000;
      lat = 2;
      expect_op(0, 32'h40c00000, 1'b0, 4);
      expect_op(1, 32'h40200000, 1'b0, 4);
      expect_op(2, 32'h40000000, 1'b0, 4);
      expect_op(3, 32'h42c80000, 1'b0, 4);
      raise(4'b1111);
      drain("all_four", 200);

      // Continuous contention between 1 and 3: strict alternation
      opa[1] = 32'h40a00000; opb[1] = 32'h3f000000;
      opa[3] = 32'h3fc00000; opb[3] = 32'h40800000;
      lat = 1;
      rearm_budget = rearm_used + 4;
      for (int k = 0; k < 3; k++) begin
         expect_op(1, 32'h40200000, 1'b0, 3);
         expect_op(3, 32'h40c00000, 1'b0, 3);
      end
      raise(4'b1010);
      drain("contention", 200);

      // Operands changed after grant must not affect the result
      @(posedge clk); #1;
      opa[0] = 32'h40000000; opb[0] = 32'h40400000;
      lat = 3;
      expect_op(0, 32'h40c00000, 1'b0, 5);
      raise(4'b0001);
      @(posedge clk); @(posedge clk); #1;
      chk("issue_dataa", 64'(mult_dataa), 64'h40000000);
      opa[0] = 32'h3f800000; opb[0] = 32'h3f800000;
      drain("stability", 60);

      // Reset mid-WAIT: aborted op never acked, req[0] served before held req[2]
      @(posedge clk); #1;
      opa[2] = 32'h41200000; opb[2] = 32'h41200000;
      lat = 10;
      raise(4'b0100);
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rstwait_busy", 64'(busy), 64'd0);
      chk("rstwait_start", 64'(mult_start), 64'd0);
      chk("rstwait_ack", 64'(ack), 64'd0);
      expect_op(0, 32'h3f800000, 1'b0, 12);
      expect_op(2, 32'h42c80000, 1'b0, 12);
      raise(4'b0001);
      drain("reset_wait", 100);

`ifdef FPMULT_ARB_TIMEOUT_EN
      // fpmult never finishes: qNaN with err 21 cycles after WAIT entry, then normal service
      @(posedge clk); #1;
      never = 1'b1;
      opa[1] = 32'h40000000; opb[1] = 32'h40000000;
      expect_op(1, 32'h7FC00000, 1'b1, 22);
      raise(4'b0010);
      drain("timeout", 100);
      @(posedge clk); #1;
      never = 1'b0;
      lat = 2;
      opa[3] = 32'h40000000; opb[3] = 32'h40400000;
      expect_op(3, 32'h40c00000, 1'b0, 4);
      raise(4'b1000);
      drain("after_timeout", 60);
`endif

      repeat (5) @(posedge clk);
      #1 chk("final_idle_busy", 64'(busy), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule
